// File: rtl/if_fetch_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
interface if_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch stage: issues imem reads, presents one instruction to decode,
// absorbs a decode stall with a one-entry skid buffer and handles redirects.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               Stall,
    input  logic [1:0]         PCsrcSel,
    input  logic [31:0]        Rs_data,
    if_fetch_if.master         imem,
    output logic [31:0]        inst_out,
    output logic               inst_en,
    output logic [31:0]        PC_out,
    output logic [31:0]        PC_plus4
);

    typedef enum logic [1:0] {StIdle, StFetch, StHold, StDrop} state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] drop_addr_q, drop_addr_d;
    logic        req_q, req_d;
    logic [31:0] inst_q, inst_d;
    logic        inst_en_q, inst_en_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] skid_inst_q, skid_inst_d;
    logic [31:0] skid_pc_q, skid_pc_d;

    logic        consume;
    logic        redirect;
    logic [31:0] pc_plus4;
    logic [31:0] target;

    assign pc_plus4       = pc_q + 32'd4;
    assign consume        = !inst_en_q || !Stall;
    assign redirect       = inst_en_q && !Stall && (PCsrcSel != 2'b00);

    // A dropped request keeps its own address while fetch_pc already holds the target.
    assign imem.imem_req  = req_q;
    assign imem.imem_addr = (state_q == StDrop) ? drop_addr_q : fetch_pc_q;

    assign inst_out = inst_q;
    assign inst_en  = inst_en_q;
    assign PC_out   = pc_q;
    assign PC_plus4 = pc_plus4;

    always_comb begin
        target = pc_plus4;
        unique case (PCsrcSel)
            2'b01:   target = pc_plus4 + {{14{inst_q[15]}}, inst_q[15:0], 2'b00};
            2'b10:   target = {pc_plus4[31:28], inst_q[25:0], 2'b00};
            2'b11:   target = Rs_data;
            default: target = pc_plus4;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        drop_addr_d = drop_addr_q;
        req_d       = req_q;
        inst_d      = inst_q;
        inst_en_d   = inst_en_q;
        pc_d        = pc_q;
        skid_inst_d = skid_inst_q;
        skid_pc_d   = skid_pc_q;

        unique case (state_q)
            StIdle: begin
                state_d = StFetch;
                req_d   = 1'b1;
            end
            StFetch: begin
                if (redirect) begin
                    fetch_pc_d = target;
                    inst_en_d  = 1'b0;
                    if (req_q && !imem.imem_ack) begin
                        state_d     = StDrop;
                        drop_addr_d = fetch_pc_q;
                    end else begin
                        req_d = 1'b1;
                    end
                end else if (req_q && imem.imem_ack) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    if (consume) begin
                        inst_d    = imem.imem_rdata;
                        pc_d      = fetch_pc_q;
                        inst_en_d = 1'b1;
                        req_d     = 1'b1;
                    end else begin
                        skid_inst_d = imem.imem_rdata;
                        skid_pc_d   = fetch_pc_q;
                        state_d     = StHold;
                        req_d       = 1'b0;
                    end
                end else begin
                    inst_en_d = inst_en_q && Stall;
                    // An outstanding request is held; otherwise issue only into a free slot.
                    if (!req_q) begin
                        req_d = consume;
                    end
                end
            end
            StHold: begin
                if (!Stall) begin
                    state_d = StFetch;
                    req_d   = 1'b1;
                    if (redirect) begin
                        fetch_pc_d = target;
                        inst_en_d  = 1'b0;
                    end else begin
                        inst_d    = skid_inst_q;
                        pc_d      = skid_pc_q;
                        inst_en_d = 1'b1;
                    end
                end
            end
            StDrop: begin
                if (imem.imem_ack) begin
                    state_d = StFetch;
                    req_d   = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            fetch_pc_q  <= RESET_PC;
            drop_addr_q <= RESET_PC;
            req_q       <= 1'b0;
            inst_q      <= 32'h0;
            inst_en_q   <= 1'b0;
            pc_q        <= 32'h0;
            skid_inst_q <= 32'h0;
            skid_pc_q   <= 32'h0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            drop_addr_q <= drop_addr_d;
            req_q       <= req_d;
            inst_q      <= inst_d;
            inst_en_q   <= inst_en_d;
            pc_q        <= pc_d;
            skid_inst_q <= skid_inst_d;
            skid_pc_q   <= skid_pc_d;
        end
    end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the address of the first fetch after reset.
REQ-002 SHALL have port clk  input  1  meaning the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  meaning the reset: asynchronous assertion, active-low.
REQ-004 SHALL have port Stall  input  1  meaning decode holds its current instruction this cycle.
REQ-005 SHALL have port PCsrcSel  input  2  meaning next-PC select from decode: 00 sequential, 01 branch taken, 10 J/Jal, 11 Jr/Jalr.
REQ-006 SHALL have port Rs_data  input  32  meaning the forwarded Rs value, used as the Jr/Jalr target.
REQ-007 SHALL have port imem_ack  input  1  meaning imem_rdata is valid and the current request completes.
REQ-008 SHALL have port imem_rdata  input  32  meaning the instruction word.
REQ-009 SHALL have port imem_req  output  1  meaning an instruction-memory read request.
REQ-010 SHALL have port imem_addr  output  32  meaning the word address of the request.
REQ-011 SHALL have port inst_out  output  32  meaning the instruction presented to decode (drives Control inst_in).
REQ-012 SHALL have port inst_en  output  1  meaning inst_out is valid.
REQ-013 SHALL have port PC_out  output  32  meaning the address of inst_out.
REQ-014 SHALL have port PC_plus4  output  32  meaning PC_out+4, used as the link value.

Function
REQ-015 Imem protocol SHALL be: once imem_req rises, imem_req and imem_addr stay stable until the cycle imem_ack=1; imem_ack may arrive in the same cycle as the request or any later cycle.
REQ-016 The FSM SHALL have four states: IDLE (first cycle after reset), FETCH (request may be issued or outstanding), HOLD (skid buffer full), DROP (wrong-path request outstanding).
REQ-017 IDLE SHALL go to FETCH unconditionally after one cycle, with imem_req=0.
REQ-018 In FETCH, a new request SHALL be issued only when the output slot is free or being consumed this cycle (inst_en=0 or Stall=0); a request already raised SHALL be held until acknowledged, whatever Stall does.
REQ-019 On imem_ack with the slot free or consumed and no redirect: inst_out<=imem_rdata, PC_out<=imem_addr, inst_en<=1, fetch_pc<=fetch_pc+4 (modulo 2^32).
REQ-020 On imem_ack while inst_en=1 and Stall=1: the data and its address SHALL go to a one-entry skid buffer, and the FSM SHALL go to HOLD.
REQ-021 In HOLD, imem_req SHALL be 0; on the first cycle with Stall=0, the skid contents SHALL move to the output, and the FSM SHALL return to FETCH.
REQ-022 A slot consumed with no replacement SHALL set inst_en<=0.
REQ-023 A redirect occurs when inst_en=1, Stall=0 and PCsrcSel!=00.
REQ-024 Redirect targets, computed from inst_out and PC_plus4: 01 -> PC_plus4 + (sign-extended inst_out[15:0] << 2); 10 -> {PC_plus4[31:28], inst_out[25:0], 2'b00}; 11 -> Rs_data.
REQ-025 On a redirect: fetch_pc<=target; inst_en<=0 next cycle (no delay slot); the skid buffer SHALL be emptied; any imem_ack in that cycle SHALL be discarded.
REQ-026 On a redirect with a request outstanding and no ack this cycle: the FSM SHALL go to DROP, hold the request until ack, discard the data, then return to FETCH with imem_addr=target.
REQ-027 In DROP, further redirects SHALL be impossible (inst_en=0); Stall SHALL be ignored.
REQ-028 PCsrcSel SHALL be ignored while inst_en=0 or Stall=1.
REQ-029 PC_plus4 SHALL always equal PC_out+4, wrapping at 2^32.

Reset
REQ-030 While rst_n=0: state=IDLE, fetch_pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, inst_out=0, inst_en=0, PC_out=0, PC_plus4=4, skid buffer empty.
REQ-031 Reset asserted mid-request or in DROP/HOLD SHALL abandon all pending state; an imem_ack arriving during or after reset for a pre-reset request SHALL never reach inst_out.

Verification
REQ-032 Reset release, ack same cycle as every request -> imem_addr 0,4,8,...; inst_en=1 from the third cycle; PC_out trails by one fetch.
REQ-033 Stall held 3 cycles while a request is acked -> inst_out stable, skid buffer captures the next word, imem_req=0 in HOLD; on release, words appear in order with no loss or duplicate.
REQ-034 PC_out=0x10, inst_out=beq with imm 0x0003, PCsrcSel=01 -> one bubble (inst_en=0), next imem_addr=0x20.
REQ-035 PC_out=0x4000_0008, J index 0x0000100, PCsrcSel=10, request outstanding, ack 2 cycles later -> DROP; wrong data discarded; next imem_addr=0x4000_0400.
REQ-036 Jr with Rs_data=0x0000_0100, ack in the redirect cycle -> data discarded; next imem_addr=0x100.
REQ-037 rst_n pulsed low while in HOLD -> all outputs at reset values immediately; fetch restarts at RESET_PC.
